// File: rtl/fwd_operand_stage.sv
// ID/EX operand register with EX-stage operand forwarding.
// Each operand compares its registered source address against EX/MEM and MEM/WB.
module fwd_operand_stage #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit FWD_EN   = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_addr_i,
   input  logic [REG_AW-1:0] id_rs2_addr_i,
   input  logic [DATA_W-1:0] id_rs1_data_i,
   input  logic [DATA_W-1:0] id_rs2_data_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              exmem_regwrite_i,
   input  logic [REG_AW-1:0] exmem_rd_i,
   input  logic [DATA_W-1:0] exmem_data_i,
   input  logic              memwb_regwrite_i,
   input  logic [REG_AW-1:0] memwb_rd_i,
   input  logic [DATA_W-1:0] memwb_data_i,
   output logic              ex_valid_o,
   output logic [REG_AW-1:0] ex_rs1_addr_o,
   output logic [REG_AW-1:0] ex_rs2_addr_o,
   output logic [DATA_W-1:0] ex_op1_o,
   output logic [DATA_W-1:0] ex_op2_o,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o
);

   localparam logic [1:0] SEL_REG   = 2'b00;
   localparam logic [1:0] SEL_EXMEM = 2'b10;
   localparam logic [1:0] SEL_MEMWB = 2'b01;

   logic valid_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_reg <= 1'b0;
      end else if (flush_i) begin
         valid_reg <= 1'b0;
      end else if (!stall_i) begin
         valid_reg <= id_valid_i;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         logic [REG_AW-1:0] addr_reg;
         logic [DATA_W-1:0] data_reg;
         logic [REG_AW-1:0] id_addr;
         logic [DATA_W-1:0] id_data;
         logic              src_ok;
         logic              hit_exmem;
         logic              hit_memwb;
         logic [1:0]        fwd_sel;
         logic [DATA_W-1:0] op;

         assign id_addr = (gi == 0) ? id_rs1_addr_i : id_rs2_addr_i;
         assign id_data = (gi == 0) ? id_rs1_data_i : id_rs2_data_i;

         // A bubble, disabled forwarding or a hardwired zero source never forwards.
         assign src_ok    = valid_reg && FWD_EN && !(ZERO_REG && (addr_reg == '0));
         assign hit_exmem = src_ok && exmem_regwrite_i && (exmem_rd_i == addr_reg);
         assign hit_memwb = src_ok && memwb_regwrite_i && (memwb_rd_i == addr_reg);

         always_comb begin
            fwd_sel = SEL_REG;
            if (hit_exmem) begin
               fwd_sel = SEL_EXMEM;
            end else if (hit_memwb) begin
               fwd_sel = SEL_MEMWB;
            end
         end

         always_comb begin
            op = data_reg;
            case (fwd_sel)
               SEL_EXMEM: op = exmem_data_i;
               SEL_MEMWB: op = memwb_data_i;
               default:   op = data_reg;
            endcase
         end

         // While stalled the forwarded value is captured so it outlives its producer.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               addr_reg <= '0;
               data_reg <= '0;
            end else if (flush_i) begin
               addr_reg <= '0;
               data_reg <= '0;
            end else if (stall_i) begin
               data_reg <= op;
            end else begin
               addr_reg <= id_addr;
               data_reg <= id_data;
            end
         end
      end
   endgenerate

   assign ex_valid_o    = valid_reg;
   assign ex_rs1_addr_o = g_opnd[0].addr_reg;
   assign ex_rs2_addr_o = g_opnd[1].addr_reg;
   assign ex_op1_o      = g_opnd[0].op;
   assign ex_op2_o      = g_opnd[1].op;
   assign fwd_a_o       = g_opnd[0].fwd_sel;
   assign fwd_b_o       = g_opnd[1].fwd_sel;

endmodule
